// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level game controller. Walks the player through the title screen, the
// arming of each level, play, the level-clear and life-lost hold screens, and
// the final game-over / victory screens. It owns the active-low reset that
// re-initialises every level datapath (map, coins, timer, sprite movers) and
// tells the top level which level's outputs to route to VGA.
//
// Ports
//   vga_clock       in   1  25 MHz pixel clock
//   reset           in   1  asynchronous, active-low
//   start_button    in   1  raw push button, active-low, asynchronous
//   level_win       in   1  win flag of the selected level
//   level_lose      in   1  lose flag of the selected level
//   level_select    out  2  index of the active level (0-based)
//   level_reset     out  1  active-low reset to all level instances
//   screen          out  3  0 TITLE 1 PLAY 2 CLEAR 3 LOST 4 GAME_OVER 5 VICTORY
//   lives           out  2  remaining lives
//   levels_cleared  out  2  levels cleared in the current game (saturates at 3)
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int NUM_LEVELS   = 3,
    parameter int START_LIVES  = 3,
    parameter int ARM_CYCLES   = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int HOLD_CYCLES  = 50_000_000
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       start_button,
    input  logic       level_win,
    input  logic       level_lose,
    output logic [1:0] level_select,
    output logic       level_reset,
    output logic [2:0] screen,
    output logic [1:0] lives,
    output logic [1:0] levels_cleared
);

    // Internal sequencing states. ARM is shown to the player as the PLAY
    // screen while the level datapaths are held in reset.
    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_ARM       = 3'd1,
        ST_PLAY      = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_LOST      = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_VICTORY   = 3'd6
    } state_t;

    // Screen codes seen by the VGA top level.
    localparam logic [2:0] SCR_TITLE     = 3'd0;
    localparam logic [2:0] SCR_PLAY      = 3'd1;
    localparam logic [2:0] SCR_CLEAR     = 3'd2;
    localparam logic [2:0] SCR_LOST      = 3'd3;
    localparam logic [2:0] SCR_GAME_OVER = 3'd4;
    localparam logic [2:0] SCR_VICTORY   = 3'd5;

    // Counter limits. Transitions fire when the counter equals (limit-1),
    // so each timed state lasts exactly `limit` cycles.
    localparam logic [25:0] ARM_LAST   = 26'(ARM_CYCLES - 1);
    localparam logic [25:0] HOLD_LAST  = 26'(HOLD_CYCLES - 1);
    localparam logic [25:0] GUARD_LIM  = 26'(GUARD_CYCLES);
    localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
    localparam logic [1:0]  LAST_LEVEL = 2'(NUM_LEVELS - 1);

    // Button synchroniser / edge detector.
    logic btn_meta_r;
    logic btn_sync_r;
    logic btn_prev_r;
    logic start_press_r;

    // Sequencer state and registered outputs.
    state_t      state_r;
    logic [25:0] cnt_r;
    logic [2:0]  screen_r;
    logic        level_reset_r;
    logic [1:0]  level_select_r;
    logic [1:0]  lives_r;
    logic [1:0]  levels_cleared_r;

    // Two-flop synchroniser then falling-edge detect; the pulse is registered,
    // giving a press-to-pulse latency of three cycles. Idle level is high so
    // nothing fires on reset release with the button untouched.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            btn_meta_r    <= 1'b1;
            btn_sync_r    <= 1'b1;
            btn_prev_r    <= 1'b1;
            start_press_r <= 1'b0;
        end else begin
            btn_meta_r    <= start_button;
            btn_sync_r    <= btn_meta_r;
            btn_prev_r    <= btn_sync_r;
            start_press_r <= btn_prev_r & ~btn_sync_r;
        end
    end

    // Game sequencer FSM. Outputs are updated in the same edge as the state,
    // so level_reset is a plain flop output and cannot glitch.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_TITLE;
            cnt_r            <= 26'd0;
            screen_r         <= SCR_TITLE;
            level_reset_r    <= 1'b0;
            level_select_r   <= 2'd0;
            lives_r          <= LIVES_INIT;
            levels_cleared_r <= 2'd0;
        end else begin
            case (state_r)
                // Idle and end screens: only a start press does anything;
                // level_select, lives and levels_cleared stay frozen.
                ST_TITLE, ST_GAME_OVER, ST_VICTORY: begin
                    if (start_press_r) begin
                        state_r          <= ST_ARM;
                        cnt_r            <= 26'd0;
                        screen_r         <= SCR_PLAY;
                        level_reset_r    <= 1'b0;
                        level_select_r   <= 2'd0;
                        lives_r          <= LIVES_INIT;
                        levels_cleared_r <= 2'd0;
                    end
                end

                // Hold the level datapaths in reset long enough for them to
                // reload their initial map, then release into play.
                ST_ARM: begin
                    if (cnt_r == ARM_LAST) begin
                        state_r       <= ST_PLAY;
                        cnt_r         <= 26'd0;
                        screen_r      <= SCR_PLAY;
                        level_reset_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 26'd1;
                    end
                end

                // The first GUARD_CYCLES cycles after release ignore the level
                // flags, which may still carry stale values from the previous
                // run. The counter stops at the limit. Win beats lose.
                ST_PLAY: begin
                    if (cnt_r < GUARD_LIM) begin
                        cnt_r <= cnt_r + 26'd1;
                    end else if (level_win) begin
                        state_r       <= ST_CLEAR;
                        cnt_r         <= 26'd0;
                        screen_r      <= SCR_CLEAR;
                        level_reset_r <= 1'b0;
                    end else if (level_lose) begin
                        state_r       <= ST_LOST;
                        cnt_r         <= 26'd0;
                        screen_r      <= SCR_LOST;
                        level_reset_r <= 1'b0;
                        lives_r       <= (lives_r == 2'd0) ? 2'd0 : (lives_r - 2'd1);
                    end
                end

                // Level-clear screen, then either the next level or victory.
                ST_CLEAR: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r            <= 26'd0;
                        levels_cleared_r <= (levels_cleared_r == 2'd3) ? 2'd3
                                                                       : (levels_cleared_r + 2'd1);
                        if (level_select_r >= LAST_LEVEL) begin
                            state_r  <= ST_VICTORY;
                            screen_r <= SCR_VICTORY;
                        end else begin
                            state_r        <= ST_ARM;
                            screen_r       <= SCR_PLAY;
                            level_select_r <= level_select_r + 2'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 26'd1;
                    end
                end

                // Life-lost screen, then replay the same level or game over.
                ST_LOST: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r <= 26'd0;
                        if (lives_r == 2'd0) begin
                            state_r  <= ST_GAME_OVER;
                            screen_r <= SCR_GAME_OVER;
                        end else begin
                            state_r  <= ST_ARM;
                            screen_r <= SCR_PLAY;
                        end
                    end else begin
                        cnt_r <= cnt_r + 26'd1;
                    end
                end

                // Unreachable encoding: recover to the title screen.
                default: begin
                    state_r          <= ST_TITLE;
                    cnt_r            <= 26'd0;
                    screen_r         <= SCR_TITLE;
                    level_reset_r    <= 1'b0;
                    level_select_r   <= 2'd0;
                    lives_r          <= LIVES_INIT;
                    levels_cleared_r <= 2'd0;
                end
            endcase
        end
    end

    assign level_select   = level_select_r;
    assign level_reset    = level_reset_r;
    assign screen         = screen_r;
    assign lives          = lives_r;
    assign levels_cleared = levels_cleared_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a short hold time.
module tb_game_sequencer;

    localparam int HOLD = 5;

    logic       vga_clock = 1'b0;
    logic       reset;
    logic       start_button;
    logic       level_win;
    logic       level_lose;
    logic [1:0] level_select;
    logic       level_reset;
    logic [2:0] screen;
    logic [1:0] lives;
    logic [1:0] levels_cleared;

    int checks = 0;
    int errors = 0;

    game_sequencer #(
        .NUM_LEVELS   (3),
        .START_LIVES  (3),
        .ARM_CYCLES   (4),
        .GUARD_CYCLES (2),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .start_button   (start_button),
        .level_win      (level_win),
        .level_lose     (level_lose),
        .level_select   (level_select),
        .level_reset    (level_reset),
        .screen         (screen),
        .lives          (lives),
        .levels_cleared (levels_cleared)
    );

    always #5 vga_clock = ~vga_clock;

    task automatic tick(input int n);
        repeat (n) @(negedge vga_clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        start_button = 1'b1;
        level_win    = 1'b0;
        level_lose   = 1'b0;
        tick(2);
        check("rst_screen", 32'(screen), 32'd0);
        check("rst_lreset", 32'(level_reset), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_sel", 32'(level_select), 32'd0);
        check("rst_cleared", 32'(levels_cleared), 32'd0);
        reset = 1'b1;
        tick(1);

        // First start: button held 10 cycles.
        start_button = 1'b0;
        tick(3);
        check("press_lat_title", 32'(screen), 32'd0);
        tick(1);
        check("press_arm_screen", 32'(screen), 32'd1);
        check("arm_lreset_first", 32'(level_reset), 32'd0);
        tick(3);
        check("arm_lreset_last", 32'(level_reset), 32'd0);
        tick(1);
        check("play_lreset", 32'(level_reset), 32'd1);
        check("play_lives", 32'(lives), 32'd3);
        check("play_sel", 32'(level_select), 32'd0);
        // Win inside the guard window is ignored.
        tick(1);
        level_win = 1'b1;
        tick(1);
        level_win = 1'b0;
        start_button = 1'b1;
        check("guard_win_ignored", 32'(screen), 32'd1);
        // Win right after the guard window is taken.
        level_win = 1'b1;
        tick(1);
        level_win = 1'b0;
        check("win_clear", 32'(screen), 32'd2);
        check("clear_lreset", 32'(level_reset), 32'd0);
        tick(HOLD - 1);
        check("clear_hold", 32'(screen), 32'd2);
        tick(1);
        check("clear_to_arm", 32'(screen), 32'd1);
        check("clear_sel", 32'(level_select), 32'd1);
        check("clear_count", 32'(levels_cleared), 32'd1);
        check("rearm_lreset", 32'(level_reset), 32'd0);

        // Three losses on level 1.
        for (int i = 0; i < 3; i++) begin
            tick(4);
            check("lose_play_lreset", 32'(level_reset), 32'd1);
            tick(2);
            level_lose = 1'b1;
            tick(1);
            level_lose = 1'b0;
            check("lose_screen", 32'(screen), 32'd3);
            check("lose_lives", 32'(lives), 32'(2 - i));
            tick(2);
            level_win = 1'b1;
            tick(1);
            level_win = 1'b0;
            check("lost_win_ignored", 32'(screen), 32'd3);
            tick(HOLD - 3);
            if (i < 2) begin
                check("lost_to_arm", 32'(screen), 32'd1);
                check("lost_sel", 32'(level_select), 32'd1);
            end else begin
                check("game_over", 32'(screen), 32'd4);
            end
        end
        tick(3);
        check("go_frozen_screen", 32'(screen), 32'd4);
        check("go_lives", 32'(lives), 32'd0);
        check("go_sel", 32'(level_select), 32'd1);
        check("go_cleared", 32'(levels_cleared), 32'd1);
        check("go_lreset", 32'(level_reset), 32'd0);

        // Restart from GAME_OVER.
        start_button = 1'b0;
        tick(4);
        start_button = 1'b1;
        check("restart_screen", 32'(screen), 32'd1);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_sel", 32'(level_select), 32'd0);
        check("restart_cleared", 32'(levels_cleared), 32'd0);

        // Simultaneous win and lose: win has priority.
        tick(6);
        level_win  = 1'b1;
        level_lose = 1'b1;
        tick(1);
        level_win  = 1'b0;
        level_lose = 1'b0;
        check("both_clear", 32'(screen), 32'd2);
        check("both_lives", 32'(lives), 32'd3);
        // Start press during the CLEAR hold is ignored.
        start_button = 1'b0;
        tick(2);
        start_button = 1'b1;
        tick(HOLD - 2);
        check("lvl0_next_screen", 32'(screen), 32'd1);
        check("lvl0_next_sel", 32'(level_select), 32'd1);
        check("lvl0_cleared", 32'(levels_cleared), 32'd1);

        // Clear level 1.
        tick(6);
        level_win = 1'b1;
        tick(1);
        level_win = 1'b0;
        check("lvl1_clear", 32'(screen), 32'd2);
        tick(HOLD);
        check("lvl1_next_sel", 32'(level_select), 32'd2);
        check("lvl1_cleared", 32'(levels_cleared), 32'd2);

        // Clear level 2 with the button held across the hold and into VICTORY.
        tick(6);
        level_win = 1'b1;
        tick(1);
        level_win = 1'b0;
        check("lvl2_clear", 32'(screen), 32'd2);
        start_button = 1'b0;
        tick(HOLD);
        check("victory_screen", 32'(screen), 32'd5);
        check("victory_cleared", 32'(levels_cleared), 32'd3);
        check("victory_sel", 32'(level_select), 32'd2);
        check("victory_lreset", 32'(level_reset), 32'd0);
        check("victory_lives", 32'(lives), 32'd3);
        tick(3);
        check("victory_held_btn", 32'(screen), 32'd5);
        start_button = 1'b1;
        level_lose = 1'b1;
        tick(2);
        level_lose = 1'b0;
        check("victory_lose_ignored", 32'(screen), 32'd5);
        check("victory_lives_frozen", 32'(lives), 32'd3);

        // Restart, lose once, then reset mid-LOST.
        start_button = 1'b0;
        tick(4);
        start_button = 1'b1;
        check("v_restart_screen", 32'(screen), 32'd1);
        check("v_restart_cleared", 32'(levels_cleared), 32'd0);
        tick(6);
        level_lose = 1'b1;
        tick(1);
        level_lose = 1'b0;
        check("mid_lost_screen", 32'(screen), 32'd3);
        check("mid_lost_lives", 32'(lives), 32'd2);
        tick(2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_screen", 32'(screen), 32'd0);
        check("async_rst_lreset", 32'(level_reset), 32'd0);
        check("async_rst_lives", 32'(lives), 32'd3);
        check("async_rst_sel", 32'(level_select), 32'd0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // Start again: same timing as the very first start.
        start_button = 1'b0;
        tick(3);
        check("p2_lat_title", 32'(screen), 32'd0);
        tick(1);
        check("p2_arm_screen", 32'(screen), 32'd1);
        tick(3);
        check("p2_arm_lreset", 32'(level_reset), 32'd0);
        tick(1);
        check("p2_play_lreset", 32'(level_reset), 32'd1);
        start_button = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller that sequences the level instances (Level1..LevelN): title screen, level start, win/lose handling, lives, level advance and end screens.
- Owns the active-low reset that re-initialises the level datapaths (map, coins, timer, Mario/Goomba movers).
- Selects which level's win/lose/background/sprite outputs the top level muxes to VGA.
- Sits between the board push button and the level modules.

Parameters:
NUM_LEVELS, 3, number of level instances; legal 1..4.
START_LIVES, 3, lives at game start; legal 1..3.
ARM_CYCLES, 4, cycles level_reset is held low before play starts; minimum 2.
GUARD_CYCLES, 2, cycles after level_reset release during which level_win and level_lose are ignored.
HOLD_CYCLES, 50_000_000, duration of the clear and lost screens (2 s at 25 MHz); benches override with a small value.

Ports:
vga_clock  in  1  system clock (25 MHz pixel clock)
reset  in  1  asynchronous, active-low
start_button  in  1  raw push button, active-low, asynchronous to vga_clock
level_win  in  1  win flag of the selected level
level_lose  in  1  lose flag of the selected level (goomba hit or timer expiry)
level_select  out  2  index of the active level, 0-based
level_reset  out  1  active-low reset to all level instances
screen  out  3  0 TITLE, 1 PLAY, 2 CLEAR, 3 LOST, 4 GAME_OVER, 5 VICTORY
lives  out  2  remaining lives
levels_cleared  out  2  count of levels cleared in the current game

Behaviour:
Reset values:
- state TITLE, screen 0, level_select 0, lives START_LIVES, levels_cleared 0, level_reset 0, all counters 0.

Start button:
- Two-flop synchroniser, then falling-edge detect produces start_press, a 1-cycle pulse.
- Press-to-pulse latency is 3 cycles. A held button yields exactly one pulse.
- start_press is ignored in ARM, PLAY, CLEAR and LOST.

level_reset:
- level_reset = 1 only in PLAY; it is 0 in every other state.
- It is registered, so it is glitch-free.

States and transitions:
- TITLE: on start_press, set lives = START_LIVES, level_select = 0, levels_cleared = 0; go to ARM.
- ARM: hold level_reset low for ARM_CYCLES cycles (cycle counter), then go to PLAY. screen = 1 while in ARM.
- PLAY: for the first GUARD_CYCLES cycles, level_win and level_lose are ignored. After that they are sampled every cycle.
  - level_win = 1: go to CLEAR. Win has priority when level_win and level_lose are asserted in the same cycle.
  - level_lose = 1 only: decrement lives (saturating at 0) and go to LOST.
- CLEAR: count HOLD_CYCLES cycles, then increment levels_cleared.
  - If level_select == NUM_LEVELS-1, go to VICTORY.
  - Otherwise increment level_select and go to ARM.
- LOST: count HOLD_CYCLES cycles.
  - If lives == 0, go to GAME_OVER.
  - Otherwise keep level_select unchanged and go to ARM (the level is replayed from its initial map).
- GAME_OVER and VICTORY: level_select, lives and levels_cleared are frozen. On start_press, re-initialise exactly as from TITLE and go to ARM.

Counter and width rules:
- A single 26-bit counter is cleared on every state entry.
- The hold/arm transition fires on the cycle the counter equals (limit-1), so each state lasts exactly limit cycles.
- level_select never exceeds NUM_LEVELS-1. levels_cleared saturates at 3.

Other boundary conditions:
- level_win or level_lose asserted outside PLAY, or inside the guard window, has no effect.
- Asserting reset in any state returns asynchronously to TITLE with the reset values above; level_reset goes low immediately.
- NUM_LEVELS = 1: CLEAR always leads to VICTORY.

Test Plan:
- Reset, then press start (held 10 cycles) → exactly one start_press. screen 0→1; level_reset low for exactly ARM_CYCLES = 4 cycles, then high; lives = 3, level_select = 0.
- In PLAY, assert level_win 1 cycle after release (inside guard) → ignored. Assert it again at cycle 3 → screen = 2 for HOLD_CYCLES; then level_select = 1, levels_cleared = 1, ARM is re-entered with level_reset low.
- Assert level_lose three times on level 1 → lives 2, 1, 0. The first two return to ARM with level_select = 1; the third goes to screen = 4 (GAME_OVER). A later start_press restarts with lives = 3, level_select = 0.
- Assert level_win and level_lose in the same cycle → CLEAR is taken; lives stays unchanged.
- Clear levels 0, 1 and 2 (NUM_LEVELS = 3) → screen = 5 (VICTORY), levels_cleared = 3, level_reset held low. start_press pulses during the CLEAR holds are ignored.
- Drop reset mid-LOST with counter partway → immediate TITLE: screen 0, level_reset 0, lives 3, counter 0. The next start behaves as in the first scenario.
